// File: rtl/gcd_8bit.sv
// Subtractive GCD engine: load samples M/N, one subtract step per clock, TC flags a valid GCD.
// Define GCD_DEBUG_EN to expose the working registers (M_, N_) and their difference (R).
module gcd_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] M,
  input  logic [7:0] N,
  input  logic       load,
`ifdef GCD_DEBUG_EN
  output logic [7:0] M_,
  output logic [7:0] N_,
  output logic [7:0] R,
`endif
  output logic [7:0] GCD,
  output logic       TC
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state, state_d;
  logic [7:0] a, a_d, b, b_d;
  logic [7:0] gcd_q, gcd_d;
  logic       tc_q, tc_d;
  logic [7:0] diff;
  logic       a_gt_b;

  // Larger minus smaller, so the step never wraps.
  assign a_gt_b = (a > b);
  assign diff   = a_gt_b ? (a - b) : (b - a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      gcd_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      state <= state_d;
      a     <= a_d;
      b     <= b_d;
      gcd_q <= gcd_d;
      tc_q  <= tc_d;
    end
  end

  always_comb begin
    state_d = state;
    a_d     = a;
    b_d     = b;
    gcd_d   = gcd_q;
    tc_d    = tc_q;
    if (load) begin
      // A load wins in every state and restarts any computation in flight.
      a_d     = M;
      b_d     = N;
      tc_d    = 1'b0;
      state_d = BUSY;
    end else begin
      case (state)
        BUSY: begin
          if (a == 8'd0) begin
            gcd_d   = b;
            tc_d    = 1'b1;
            state_d = DONE;
          end else if (b == 8'd0 || a == b) begin
            gcd_d   = a;
            tc_d    = 1'b1;
            state_d = DONE;
          end else if (a_gt_b) begin
            a_d = diff;
          end else begin
            b_d = diff;
          end
        end
        default: ;
      endcase
    end
  end

  assign GCD = gcd_q;
  assign TC  = tc_q;

`ifdef GCD_DEBUG_EN
  assign M_ = a;
  assign N_ = b;
  assign R  = diff;
`endif

endmodule

// File: tb/tb_gcd_8bit.sv
// Self-checking bench for gcd_8bit: directed cases plus random operands against a
// Euclid (modulo) reference that predicts both the result and the completion latency.
module tb_gcd_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] M, N;
  logic       load;
  logic [7:0] GCD;
  logic       TC;
`ifdef GCD_DEBUG_EN
  logic [7:0] M_, N_, R;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_gcd = 0;

  always #5 clk = ~clk;

  gcd_8bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .M    (M),
    .N    (N),
    .load (load),
`ifdef GCD_DEBUG_EN
    .M_   (M_),
    .N_   (N_),
    .R    (R),
`endif
    .GCD  (GCD),
    .TC   (TC)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Edges from load to TC: subtractive Euclid performs (sum of quotients - 1)
  // subtractions, plus one completion edge; a zero operand finishes on the first edge.
  function automatic int ref_lat(input int a, input int b);
    int k = 0, t;
    if (a == 0 || b == 0) return 1;
    while (b != 0) begin
      k += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return k;
  endfunction

  // Called at a falling edge; returns at a falling edge with TC observed high (or timed out).
  task automatic run(input int m, input int n);
    int i, lat, g;
    lat = ref_lat(m, n);
    g   = ref_gcd(m, n);
    M = m[7:0]; N = n[7:0]; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (TC) break;
      if (i == 1 || i % 16 == 0) chk($sformatf("hold(%0d,%0d)", m, n), GCD, exp_gcd);
    end
    chk($sformatf("lat(%0d,%0d)", m, n), i, lat);
    chk($sformatf("gcd(%0d,%0d)", m, n), GCD, g);
    exp_gcd = g;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; M = 8'd5; N = 8'd5;
    repeat (3) @(negedge clk);
    chk("rst_gcd", GCD, 0);
    chk("rst_tc", TC, 0);

    // Load at the very first edge after release.
    rst_n = 1'b1;
    run(10, 20);
    run(10, 22);
    exp_gcd = 2;
    run(36, 60);
    run(0, 9);
    run(7, 7);
    run(255, 1);
    run(0, 0);
    run(9, 0);

    // DONE holds while operands wander without load.
    for (int i = 0; i < 4; i++) begin
      M = 8'($urandom); N = 8'($urandom);
      @(negedge clk);
      chk("done_tc", TC, 1);
      chk("done_gcd", GCD, exp_gcd);
    end

    // Re-load aborts a long computation.
    M = 8'd255; N = 8'd1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_tc", TC, 0);
    chk("abort_gcd", GCD, exp_gcd);
    run(36, 60);

    // Asynchronous reset mid-computation.
    M = 8'd255; N = 8'd1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gcd", GCD, 0);
    chk("arst_tc", TC, 0);
    exp_gcd = 0;
    @(negedge clk);
    chk("arst_hold_tc", TC, 0);
    rst_n = 1'b1;
    run(12, 18);

    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_8bit.md
GCD_8BIT -- requirements
Module: gcd_8bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- M  input  8  unsigned operand A, sampled when load=1
- N  input  8  unsigned operand B, sampled when load=1
- load  input  1  start request, sampled on a rising clk edge
- GCD  output  8  registered result, unsigned
- TC  output  1  terminal count: result valid, level signal
REQ-003 Debug-only ports under GCD_DEBUG_EN:
- M_  output  8  working register A
- N_  output  8  working register B
- R  output  8  |A-B|, combinational

Function
REQ-004 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-005 If load=1 at a rising edge, in any state, the block SHALL perform all of the following:
- A<=M and B<=N
- TC<=0
- go to BUSY
- an in-progress computation is aborted
REQ-006 In BUSY, exactly one step SHALL occur per clock edge, with priority in this order:
- A==0: GCD<=B, TC<=1, go to DONE
- else B==0: GCD<=A, TC<=1, go to DONE
- else A==B: GCD<=A, TC<=1, go to DONE
- else A>B: A<=A-B
- else: B<=B-A
REQ-007 Subtraction SHALL be 8-bit unsigned and SHALL never underflow, because the smaller operand is always subtracted from the larger.
REQ-008 Latency: with k subtractions needed, TC SHALL rise k+1 edges after the load edge; the worst case is M=255, N=1, which needs 254 subtractions, so TC rises 255 edges after the load edge.
REQ-009 M=N=0 SHALL give GCD=0 with TC rising 1 edge after load.
REQ-010 GCD SHALL change only on completion (REQ-006) or reset, and SHALL hold the previous result while BUSY.
REQ-011 In DONE, TC SHALL remain 1 and GCD SHALL hold until the next load or reset.
REQ-012 In IDLE and DONE, A and B SHALL hold their values.
REQ-013 M and N changes without load=1 SHALL have no effect.

Reset
REQ-014 When rst_n=0, asynchronously:
- state=IDLE
- A=0, B=0
- GCD=0, TC=0
REQ-015 Reset asserted mid-computation SHALL abort it.
REQ-016 A load at the first edge after reset release SHALL be accepted.

Configuration
REQ-017 The macro GCD_DEBUG_EN SHALL control the debug ports:
- defined: M_, N_ and R exist per REQ-003
- undefined: these ports are absent
- the functional behaviour is identical in both cases

Verification
REQ-018 Reset: rst_n=0 with load=1 -> GCD=0, TC=0, no computation starts.
REQ-019 Load M=10, N=20 -> after 2 edges, TC=1 and GCD=10.
REQ-020 Load M=10, N=22 -> after 7 edges, TC=1 and GCD=2; TC=0 during the intermediate cycles.
REQ-021 Load M=36, N=60 -> after 4 edges, TC=1 and GCD=12; GCD holds 2 (the previous result) until completion.
REQ-022 Boundary cases:
- M=0, N=9 -> GCD=9
- M=7, N=7 -> GCD=7
- M=255, N=1 -> GCD=1 after 255 edges
REQ-023 Re-load M=36, N=60 while a prior M=255, N=1 is BUSY -> the prior computation is aborted and GCD=12 with TC rising 4 edges after the re-load.
